demux_4: RTL and testbench

Registered 1-to-4 stream demultiplexer, the distributing counterpart of the datapath 4-way selector. It accepts one word per cycle from a single valid/ready source and steers it, by a 2-bit select, into one of four independent 2-entry output buffers. Each buffer presents its own valid/ready port to a downstream consumer. A stalled consumer therefore blocks only traffic addressed to it.

---
 rtl/demux_4_if.sv | 30 +++
 rtl/demux_4.sv | 69 ++++++
 tb/tb_demux_4.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/demux_4_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// demux_4_if : source + four consumer ports of the 1-to-4 stream demux
// Rev 1.0
// ----------------------------------------------------------------------------
interface demux_4_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic [1:0]            in_sel;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic [3:0]            out_valid;
   logic [3:0]            out_ready;
   logic [DATA_WIDTH-1:0] out_data0;
   logic [DATA_WIDTH-1:0] out_data1;
   logic [DATA_WIDTH-1:0] out_data2;
   logic [DATA_WIDTH-1:0] out_data3;

   // master: the environment (source and consumers); slave: the demux itself
   modport master (
      output in_valid, in_sel, in_data, out_ready,
      input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
   );
   modport slave (
      input  in_valid, in_sel, in_data, out_ready,
      output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3
   );
endinterface
`default_nettype wire

// File: rtl/demux_4.sv
`default_nettype none
// ----------------------------------------------------------------------------
// demux_4 : registered 1-to-4 stream demux, one 2-entry buffer per channel
// Rev 1.0
// ----------------------------------------------------------------------------
module demux_4 #(
   parameter int DATA_WIDTH = 32
) (
   input  wire        clk,
   input  wire        reset,
   demux_4_if.slave   bus
);
   localparam int C_CHANNELS = 4;

   logic [C_CHANNELS-1:0]                 w_full;
   logic [C_CHANNELS-1:0]                 w_nempty;
   logic [C_CHANNELS-1:0][DATA_WIDTH-1:0] w_head;

   genvar n;
   generate
      for (n = 0; n < C_CHANNELS; n++) begin : g_ch
         logic [1:0]            r_cnt;
         logic                  r_rp;
         logic [DATA_WIDTH-1:0] r_mem0;
         logic [DATA_WIDTH-1:0] r_mem1;
         logic                  w_push;
         logic                  w_pop;
         logic                  w_wslot;

         // A full channel refuses even when it pops this cycle, so in_ready
         // never depends on out_ready.
         assign w_push  = bus.in_valid && (bus.in_sel == 2'(n)) && (r_cnt != 2'd2);
         assign w_pop   = (r_cnt != 2'd0) && bus.out_ready[n];
         assign w_wslot = r_rp ^ (r_cnt == 2'd1);

         always_ff @(posedge clk) begin
            if (reset) begin
               r_cnt  <= 2'd0;
               r_rp   <= 1'b0;
               r_mem0 <= '0;
               r_mem1 <= '0;
            end else begin
               if (w_push) begin
                  if (w_wslot) r_mem1 <= bus.in_data;
                  else         r_mem0 <= bus.in_data;
               end
               case ({w_push, w_pop})
                  2'b10:   r_cnt <= r_cnt + 2'd1;
                  2'b01:   r_cnt <= r_cnt - 2'd1;
                  default: r_cnt <= r_cnt;
               endcase
               if (w_pop) r_rp <= ~r_rp;
            end
         end

         assign w_full[n]   = (r_cnt == 2'd2);
         assign w_nempty[n] = (r_cnt != 2'd0);
         assign w_head[n]   = r_rp ? r_mem1 : r_mem0;
      end
   endgenerate

   assign bus.in_ready  = ~w_full[bus.in_sel];
   assign bus.out_valid = w_nempty;
   assign bus.out_data0 = w_head[0];
   assign bus.out_data1 = w_head[1];
   assign bus.out_data2 = w_head[2];
   assign bus.out_data3 = w_head[3];
endmodule
`default_nettype wire

// File: tb/tb_demux_4.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_demux_4 : randomized + directed bench for demux_4 against a queue model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_demux_4;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_fail;
   logic chk_en;

   demux_4_if #(.DATA_WIDTH(32)) bus ();

   demux_4 #(.DATA_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: one FIFO queue per channel, capacity 2.
   logic [31:0] mq [4][$];

   always @(posedge clk) begin
      logic acc;
      if (reset) begin
         for (int c = 0; c < 4; c++) mq[c].delete();
      end else begin
         acc = bus.in_valid && (mq[bus.in_sel].size() < 2);
         for (int c = 0; c < 4; c++)
            if (mq[c].size() != 0 && bus.out_ready[c]) void'(mq[c].pop_front());
         if (acc) mq[bus.in_sel].push_back(bus.in_data);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] head(input int c);
      case (c)
         0:       return bus.out_data0;
         1:       return bus.out_data1;
         2:       return bus.out_data2;
         default: return bus.out_data3;
      endcase
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         for (int c = 0; c < 4; c++) begin
            chk($sformatf("valid%0d", c), 32'(bus.out_valid[c]), 32'(mq[c].size() != 0));
            if (mq[c].size() != 0) chk($sformatf("data%0d", c), head(c), mq[c][0]);
         end
         chk("in_ready", 32'(bus.in_ready), 32'(mq[bus.in_sel].size() != 2));
      end
   end

   task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
      bus.in_valid  = v;
      bus.in_sel    = s;
      bus.in_data   = d;
      bus.out_ready = r;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      chk_en = 1'b0;
      reset  = 1'b1;
      drive(1'b0, 2'd0, 32'h0, 4'h0);
      step();
      step();
      reset  = 1'b0;
      chk_en = 1'b1;

      // Reset / idle
      chk("rst_valid", 32'(bus.out_valid), 32'h0);
      for (int c = 0; c < 4; c++) chk($sformatf("rst_data%0d", c), head(c), 32'h0);
      for (int s = 0; s < 4; s++) begin
         bus.in_sel = 2'(s);
         #1;
         chk($sformatf("rst_ready_sel%0d", s), 32'(bus.in_ready), 32'h1);
      end

      // Single word to ch2
      drive(1'b1, 2'd2, 32'hAAAA0001, 4'h0);
      step();
      drive(1'b0, 2'd2, 32'h0, 4'h0);
      chk("single_valid", 32'(bus.out_valid), 32'h4);
      chk("single_data2", bus.out_data2, 32'hAAAA0001);
      chk("single_data0", bus.out_data0, 32'h0);
      bus.out_ready = 4'b0100;
      step();
      bus.out_ready = 4'b0000;
      chk("single_drained", 32'(bus.out_valid), 32'h0);

      // Fill and backpressure on ch0
      drive(1'b1, 2'd0, 32'h11, 4'h0);
      step();
      drive(1'b1, 2'd0, 32'h22, 4'h0);
      step();
      drive(1'b1, 2'd0, 32'h33, 4'h0);
      #1;
      chk("fill_ready0", 32'(bus.in_ready), 32'h0);
      for (int k = 0; k < 3; k++) step();
      chk("fill_head", bus.out_data0, 32'h11);
      drive(1'b0, 2'd1, 32'h0, 4'h0);
      #1;
      chk("fill_ready1", 32'(bus.in_ready), 32'h1);
      bus.out_ready = 4'b0001;
      step();
      chk("fill_pop2", bus.out_data0, 32'h22);
      step();
      bus.out_ready = 4'b0000;
      chk("fill_empty", 32'(bus.out_valid), 32'h0);

      // Streaming into ch3
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 2'd3, 32'h100 + 32'(i), 4'b1000);
         #1;
         chk("stream_ready", 32'(bus.in_ready), 32'h1);
         step();
         chk("stream_data", bus.out_data3, 32'h100 + 32'(i));
      end
      drive(1'b0, 2'd3, 32'h0, 4'b1000);
      step();
      chk("stream_done", 32'(bus.out_valid), 32'h0);

      // Full channel with simultaneous pop
      drive(1'b1, 2'd1, 32'hA1, 4'h0);
      step();
      drive(1'b1, 2'd1, 32'hA2, 4'h0);
      step();
      drive(1'b1, 2'd1, 32'h55, 4'b0010);
      #1;
      chk("fullpop_ready", 32'(bus.in_ready), 32'h0);
      step();
      chk("fullpop_head", bus.out_data1, 32'hA2);
      chk("fullpop_ready_next", 32'(bus.in_ready), 32'h1);
      bus.out_ready = 4'b0000;
      step();
      drive(1'b0, 2'd1, 32'h0, 4'b0010);
      chk("fullpop_refull", 32'(bus.in_ready), 32'h0);
      step();
      chk("fullpop_55", bus.out_data1, 32'h55);
      step();
      bus.out_ready = 4'b0000;
      chk("fullpop_empty", 32'(bus.out_valid), 32'h0);

      // Round-robin then random traffic
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0,
               (i < 200) ? 2'(i % 4) : 2'($urandom_range(0, 3)),
               $urandom, 4'($urandom_range(0, 15)));
         step();
      end

      // Reset while every channel holds data
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 2'(i % 4), $urandom, 4'h0);
         step();
      end
      drive(1'b0, 2'd0, 32'h0, 4'h0);
      chk("pre_rst_valid", 32'(bus.out_valid), 32'hF);
      reset = 1'b1;
      drive(1'b1, 2'd2, 32'hDEAD, 4'hF);
      step();
      reset = 1'b0;
      drive(1'b0, 2'd0, 32'h0, 4'hF);
      chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
      for (int c = 0; c < 4; c++) chk($sformatf("mid_rst_data%0d", c), head(c), 32'h0);
      for (int i = 0; i < 8; i++) step();

      for (int i = 0; i < 200; i++) begin
         drive($urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)),
               $urandom, 4'($urandom_range(0, 15)));
         step();
      end
      drive(1'b0, 2'd0, 32'h0, 4'hF);
      step();
      step();
      chk("final_empty", 32'(bus.out_valid), 32'h0);

      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
